// File: rtl/countdown_display_if.sv
// Timer-to-display bundle: binary minutes/seconds and done flag in,
// multiplexed 7-segment drive and flash status out.
interface countdown_display_if;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       flash;

    modport master (
        output minutes, seconds, done,
        input  an, seg, dp, flash
    );

    modport slave (
        input  minutes, seconds, done,
        output an, seg, dp, flash
    );
endinterface

// File: rtl/countdown_display.sv
// MM.SS display stage: iterative double-dabble conversion, time-multiplexed
// 4-digit scan, and a fixed-length blink sequence triggered by done.
module countdown_display #(
    parameter int unsigned SCAN_DIV      = 100000,
    parameter int unsigned BLINK_DIV     = 25000000,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input logic                clk,
    input logic                reset,
    countdown_display_if.slave disp_io
);
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TogW   = $clog2(FLASH_TOGGLES + 1);
    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [TogW-1:0]   TogEnd    = TogW'(FLASH_TOGGLES);

    typedef enum logic [1:0] {StLoad, StShift, StCommit} conv_st_e;

    function automatic logic [6:0] clamp99(logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // One double-dabble step on {bcd tens, bcd ones, remaining binary}.
    function automatic logic [14:0] dabble(logic [14:0] s);
        logic [14:0] t;
        t = s;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_enc(logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    conv_st_e    conv_q;
    logic [2:0]  shcnt_q;
    logic [14:0] msh_q, ssh_q;
    logic [3:0]  mt_q, mo_q, st_q, so_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conv_q  <= StLoad;
            shcnt_q <= '0;
            msh_q   <= '0;
            ssh_q   <= '0;
            mt_q    <= '0;
            mo_q    <= '0;
            st_q    <= '0;
            so_q    <= '0;
        end else begin
            unique case (conv_q)
                StLoad: begin
                    msh_q   <= {8'd0, clamp99(disp_io.minutes)};
                    ssh_q   <= {8'd0, clamp99(disp_io.seconds)};
                    shcnt_q <= '0;
                    conv_q  <= StShift;
                end
                StShift: begin
                    msh_q   <= dabble(msh_q);
                    ssh_q   <= dabble(ssh_q);
                    shcnt_q <= shcnt_q + 3'd1;
                    if (shcnt_q == 3'd6) conv_q <= StCommit;
                end
                StCommit: begin
                    mt_q   <= msh_q[14:11];
                    mo_q   <= msh_q[10:7];
                    st_q   <= ssh_q[14:11];
                    so_q   <= ssh_q[10:7];
                    conv_q <= StLoad;
                end
                default: conv_q <= StLoad;
            endcase
        end
    end

    logic [ScanW-1:0]  scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [BlinkW-1:0] half_q, half_d;
    logic [TogW-1:0]   tog_q, tog_d;
    logic              flash_q, flash_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        digit;

    always_comb begin
        scan_d = scan_q + ScanW'(1);
        idx_d  = idx_q;
        if (scan_q == ScanLast) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end

        half_d  = half_q;
        tog_d   = tog_q;
        flash_d = flash_q;
        if (disp_io.done) begin
            half_d  = '0;
            tog_d   = '0;
            flash_d = 1'b1;
        end else if (flash_q) begin
            if (half_q == BlinkLast) begin
                half_d = '0;
                tog_d  = tog_q + TogW'(1);
                if (tog_d == TogEnd) begin
                    flash_d = 1'b0;
                    tog_d   = '0;
                end
            end else begin
                half_d = half_q + BlinkW'(1);
            end
        end

        digit = so_q;
        unique case (idx_q)
            2'd0: digit = so_q;
            2'd1: digit = st_q;
            2'd2: digit = mo_q;
            2'd3: digit = mt_q;
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_enc(digit);
        dp_d  = (idx_q != 2'd2);
        if (idx_q == 2'd3 && mt_q == 4'd0) seg_d = 7'h7F;
        // Mask from next-state so blanking lines up with the flash flag.
        if (flash_d && !tog_d[0]) begin
            an_d = 4'hF;
            dp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q  <= '0;
            idx_q   <= '0;
            half_q  <= '0;
            tog_q   <= '0;
            flash_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            tog_q   <= tog_d;
            flash_q <= flash_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp_io.an    = an_q;
    assign disp_io.seg   = seg_q;
    assign disp_io.dp    = dp_q;
    assign disp_io.flash = flash_q;
endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display with small scan/blink dividers.
module tb_countdown_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, BL = 7'b1111111;

    typedef struct {
        logic [6:0]       minutes;
        logic [6:0]       seconds;
        logic [3:0][6:0]  seg;     // [3] = leftmost digit
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    vec_t tbl[8];

    countdown_display_if disp_if ();

    countdown_display #(
        .SCAN_DIV      (4),
        .BLINK_DIV     (8),
        .FLASH_TOGGLES (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .disp_io (disp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vector(input int vi);
        exp_t       e;
        logic [3:0] prev_an;
        bit         found;
        disp_if.minutes = tbl[vi].minutes;
        disp_if.seconds = tbl[vi].seconds;
        repeat (20) step();
        for (int i = 0; i < 4; i++) begin
            e.an    = 4'hF;
            e.an[i] = 1'b0;
            e.seg   = tbl[vi].seg[i];
            e.dp    = (i != 2);
            sb.push_back(e);
        end
        prev_an = disp_if.an;
        found   = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (disp_if.an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
            else prev_an = disp_if.an;
        end
        if (!found) begin
            check($sformatf("vec%0d scan_align", vi), 16'(disp_if.an), 16'hE);
            repeat (4) void'(sb.pop_front());
        end else begin
            for (int d = 0; d < 4; d++) begin
                e = sb.pop_front();
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("vec%0d dig%0d cyc%0d an", vi, d, c), 16'(disp_if.an), 16'(e.an));
                    check($sformatf("vec%0d dig%0d cyc%0d seg", vi, d, c), 16'(disp_if.seg), 16'(e.seg));
                    check($sformatf("vec%0d dig%0d cyc%0d dp", vi, d, c), 16'(disp_if.dp), 16'(e.dp));
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic flash_cycle(input string tag, input int k);
        logic fl;
        logic blank;
        fl    = (k < 48);
        blank = fl && ((k / 8) % 2 == 0);
        check($sformatf("%s k%0d flash", tag, k), 16'(disp_if.flash), 16'(fl));
        if (blank) begin
            check($sformatf("%s k%0d an_blank", tag, k), 16'(disp_if.an), 16'hF);
            check($sformatf("%s k%0d dp_blank", tag, k), 16'(disp_if.dp), 16'h1);
        end else begin
            check($sformatf("%s k%0d an_onehot", tag, k), 16'($countones(~disp_if.an)), 16'h1);
        end
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, " an"}, 16'(disp_if.an), 16'hF);
        check({tag, " seg"}, 16'(disp_if.seg), 16'h7F);
        check({tag, " dp"}, 16'(disp_if.dp), 16'h1);
        check({tag, " flash"}, 16'(disp_if.flash), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{minutes: 7'd25,  seconds: 7'd0,   seg: {S2, S5, S0, S0}};
        tbl[1] = '{minutes: 7'd0,   seconds: 7'd9,   seg: {BL, S0, S0, S9}};
        tbl[2] = '{minutes: 7'd7,   seconds: 7'd30,  seg: {BL, S7, S3, S0}};
        tbl[3] = '{minutes: 7'd10,  seconds: 7'd48,  seg: {S1, S0, S4, S8}};
        tbl[4] = '{minutes: 7'd63,  seconds: 7'd16,  seg: {S6, S3, S1, S6}};
        tbl[5] = '{minutes: 7'd100, seconds: 7'd59,  seg: {S9, S9, S5, S9}};
        tbl[6] = '{minutes: 7'd99,  seconds: 7'd127, seg: {S9, S9, S9, S9}};
        tbl[7] = '{minutes: 7'd120, seconds: 7'd75,  seg: {S9, S9, S7, S5}};

        disp_if.minutes = 7'd25;
        disp_if.seconds = 7'd0;
        disp_if.done    = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        for (int vi = 0; vi < 8; vi++) run_vector(vi);

        // Async reset while converting, then exact commit timing from release.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 reset_outputs("rst_conv");
        disp_if.minutes = 7'd3;
        disp_if.seconds = 7'd59;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            case (k)
                9: begin
                    check("commit1_pre an", 16'(disp_if.an), 16'hB);
                    check("commit1_pre seg", 16'(disp_if.seg), 16'(S0));
                    check("commit1_pre dp", 16'(disp_if.dp), 16'h0);
                end
                10: check("commit1_post seg", 16'(disp_if.seg), 16'(S3));
                11: begin
                    disp_if.minutes = 7'd4;
                    disp_if.seconds = 7'd58;
                end
                18: begin
                    check("hold59_a an", 16'(disp_if.an), 16'hE);
                    check("hold59_a seg", 16'(disp_if.seg), 16'(S9));
                end
                19: check("hold59_b seg", 16'(disp_if.seg), 16'(S9));
                27: begin
                    check("commit3_pre an", 16'(disp_if.an), 16'hB);
                    check("commit3_pre seg", 16'(disp_if.seg), 16'(S3));
                end
                28: check("commit3_post seg", 16'(disp_if.seg), 16'(S4));
                33: begin
                    check("new58 an", 16'(disp_if.an), 16'hE);
                    check("new58 seg", 16'(disp_if.seg), 16'(S8));
                end
                default: ;
            endcase
        end

        // Single done pulse.
        disp_if.done = 1'b1;
        step();
        disp_if.done = 1'b0;
        for (int k = 0; k <= 48; k++) begin
            flash_cycle("pulse", k);
            step();
        end

        // Retrigger at flash cycle 20.
        disp_if.done = 1'b1;
        step();
        disp_if.done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            flash_cycle("pre_rt", k);
            if (k == 19) disp_if.done = 1'b1;
            step();
        end
        disp_if.done = 1'b0;
        for (int k = 0; k <= 48; k++) begin
            flash_cycle("retrig", k);
            step();
        end

        // done held high keeps the display blank.
        disp_if.done = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("held k%0d an", k), 16'(disp_if.an), 16'hF);
            check($sformatf("held k%0d flash", k), 16'(disp_if.flash), 16'h1);
        end
        disp_if.done = 1'b0;
        repeat (50) step();
        check("held_end flash", 16'(disp_if.flash), 16'h0);

        // Async reset in the middle of a flash.
        disp_if.done = 1'b1;
        step();
        disp_if.done = 1'b0;
        repeat (10) step();
        check("midflash flash", 16'(disp_if.flash), 16'h1);
        #2 reset = 1'b0;
        #1 reset_outputs("rst_flash");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step();
        check("post_rst flash", 16'(disp_if.flash), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
